vga_frame_reader: RTL and testbench

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

---
 rtl/vga_frame_reader.sv | 118 +++++++++++
 tb/tb_vga_frame_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Scans out a frame buffer as VGA timing plus RGB444 pixels. The counters free-run.
// The read address tracks the counter. All pins are 2 clk behind the counters, and there is no backpressure.
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        display_en,
  output logic [18:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] vga_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [18:0] ADDR_MAX = 19'(V_ACTIVE * H_ACTIVE - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [18:0]   rd_addr_q, rd_addr_d;
  logic          h_wrap, active0, hsync0_n, vsync0_n, fs0;

  logic          hsync1_q, hsync1_d, vsync1_q, vsync1_d;
  logic          de1_q, de1_d, fs1_q, fs1_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, fs_q, fs_d;
  logic [11:0]   rgb_q, rgb_d;

  // Stage 0: raster position and the timing it implies.
  always_comb begin
    h_wrap  = (h_cnt_q == HW'(H_TOTAL - 1));
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
    end
    active0  = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    hsync0_n = !((h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                 (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    vsync0_n = !((v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                 (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC)));
    fs0      = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // The address register holds the address for the current counter position.
  // It reloads from the next position so that vertical blanking always sees 0.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (v_cnt_d >= VW'(V_ACTIVE)) begin
      rd_addr_d = '0;
    end else if (active0 && (rd_addr_q != ADDR_MAX)) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  always_comb begin
    hsync1_d = hsync0_n;
    vsync1_d = vsync0_n;
    de1_d    = active0;
    fs1_d    = fs0;
    hsync_d  = hsync1_q;
    vsync_d  = vsync1_q;
    de_d     = de1_q;
    fs_d     = fs1_q;
    rgb_d    = (de1_q && display_en) ? rd_data : 12'h000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      rd_addr_q <= '0;
      hsync1_q  <= 1'b1;
      vsync1_q  <= 1'b1;
      de1_q     <= 1'b0;
      fs1_q     <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      rgb_q     <= 12'h000;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      rd_addr_q <= rd_addr_d;
      hsync1_q  <= hsync1_d;
      vsync1_q  <= vsync1_d;
      de1_q     <= de1_d;
      fs1_q     <= fs1_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign vga_rgb     = rgb_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader using a shrunken raster (16x11 clocks, 8x6 visible).
module tb_vga_frame_reader;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        display_en;
  logic [18:0] rd_addr;
  logic [11:0] rd_data;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] vga_rgb;
  logic [15:0] obs, e;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  always #5 clk = ~clk;

  // The frame-buffer model returns the low 12 address bits one clock later.
  always @(posedge clk) rd_data <= rd_addr[11:0];

  assign obs = {hsync, vsync, de, frame_start, vga_rgb};

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .display_en(display_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .hsync(hsync), .vsync(vsync), .de(de),
    .vga_rgb(vga_rgb), .frame_start(frame_start)
  );

  // Expected pins for pixel index p since release. Negative p gives the reset values.
  function automatic logic [15:0] exp_pins(int p, logic en);
    int q, x, y;
    logic hs, vs, d, fs;
    logic [11:0] rgb;
    if (p < 0) return 16'hC000;
    q   = p % FR;
    x   = q % HT;
    y   = q / HT;
    hs  = !(x >= HA + HF && x < HA + HF + HS);
    vs  = !(y >= VA + VF && y < VA + VF + VS);
    d   = (x < HA) && (y < VA);
    fs  = (x == 0) && (y == 0);
    rgb = (d && en) ? 12'(y * HA + x) : 12'h000;
    return {hs, vs, d, fs, rgb};
  endfunction

  function automatic logic [18:0] exp_addr(int c);
    int q, x, y;
    q = c % FR;
    x = q % HT;
    y = q / HT;
    if (y >= VA) return 19'd0;
    if (x < HA) return 19'(y * HA + x);
    if (y == VA - 1) return 19'(VA * HA - 1);
    return 19'((y + 1) * HA);
  endfunction

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  // Advance until (k - off) mod FR == tgt. off=2 selects pin position, and off=0 selects counter position.
  task automatic run_to(int tgt, int off);
    int n = 0;
    while (!((k >= off) && ((k - off) % FR == tgt)) && n < 3 * FR) begin
      step();
      n++;
    end
    if (n >= 3 * FR) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_to timeout target %0d", tgt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    display_en = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 16'hC000) begin n_fail++; $display("FAIL reset_pins got %h exp %h", obs, 16'hC000); end
    n_checks++;
    if (rd_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", rd_addr); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== 16'hC000) begin n_fail++; $display("FAIL reset_hold_pins got %h exp %h", obs, 16'hC000); end
    reset = 1'b1;
    k = 0;
    #1;
    n_checks++;
    if (rd_addr !== 19'd0) begin n_fail++; $display("FAIL release_addr got %0d exp 0", rd_addr); end
  endtask

  task automatic test_frame_timing();
    int hs_lo = 0, vs_lo = 0, de_hi = 0, fs_n = 0, p;
    for (int i = 0; i < 2 * FR + 2; i++) begin
      step();
      p = k - 2;
      e = exp_pins(p, 1'b1);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL timing_pins p=%0d got %h exp %h", p, obs, e); end
      n_checks++;
      if (rd_addr !== exp_addr(k)) begin
        n_fail++; $display("FAIL timing_addr c=%0d got %0d exp %0d", k, rd_addr, exp_addr(k));
      end
      if (p >= 0 && p < 2 * FR) begin
        if (!hsync) hs_lo++;
        if (!vsync) vs_lo++;
        if (de) de_hi++;
        if (frame_start) fs_n++;
      end
    end
    n_checks++;
    if (hs_lo != 2 * VT * HS) begin n_fail++; $display("FAIL hsync_low_count got %0d exp %0d", hs_lo, 2 * VT * HS); end
    n_checks++;
    if (vs_lo != 2 * HT * VS) begin n_fail++; $display("FAIL vsync_low_count got %0d exp %0d", vs_lo, 2 * HT * VS); end
    n_checks++;
    if (de_hi != 2 * HA * VA) begin n_fail++; $display("FAIL de_count got %0d exp %0d", de_hi, 2 * HA * VA); end
    n_checks++;
    if (fs_n != 2) begin n_fail++; $display("FAIL frame_start_count got %0d exp 2", fs_n); end
  endtask

  task automatic test_pixel_data();
    run_to(1 * HT + 5, 2);
    n_checks++;
    if (vga_rgb !== 12'h00D) begin n_fail++; $display("FAIL pixel_5_1 got %h exp 00d", vga_rgb); end
    run_to(2 * HT + 3, 2);
    n_checks++;
    if (vga_rgb !== 12'h013) begin n_fail++; $display("FAIL pixel_3_2 got %h exp 013", vga_rgb); end
    run_to(5 * HT + 7, 2);
    n_checks++;
    if (vga_rgb !== 12'h02F) begin n_fail++; $display("FAIL pixel_7_5 got %h exp 02f", vga_rgb); end
    step();
    n_checks++;
    if ({de, vga_rgb} !== 13'h0000) begin n_fail++; $display("FAIL pixel_hblank got %h exp 0000", {de, vga_rgb}); end
    run_to(0, 2);
    n_checks++;
    if ({de, frame_start, vga_rgb} !== 14'h3000) begin
      n_fail++; $display("FAIL pixel_0_0 got %h exp 3000", {de, frame_start, vga_rgb});
    end
  endtask

  task automatic test_rd_addr();
    run_to(5 * HT + 7, 0);
    n_checks++;
    if (rd_addr !== 19'd47) begin n_fail++; $display("FAIL addr_last got %0d exp 47", rd_addr); end
    step();
    n_checks++;
    if (rd_addr !== 19'd47) begin n_fail++; $display("FAIL addr_hold_last got %0d exp 47", rd_addr); end
    run_to(6 * HT, 0);
    n_checks++;
    if (rd_addr !== 19'd0) begin n_fail++; $display("FAIL addr_vblank_first got %0d exp 0", rd_addr); end
    run_to(10 * HT + 15, 0);
    n_checks++;
    if (rd_addr !== 19'd0) begin n_fail++; $display("FAIL addr_vblank_last got %0d exp 0", rd_addr); end
    step();
    n_checks++;
    if (rd_addr !== 19'd0) begin n_fail++; $display("FAIL addr_frame_origin got %0d exp 0", rd_addr); end
    step();
    n_checks++;
    if (rd_addr !== 19'd1) begin n_fail++; $display("FAIL addr_pixel1 got %0d exp 1", rd_addr); end
    run_to(HT - 1, 0);
    n_checks++;
    if (rd_addr !== 19'd8) begin n_fail++; $display("FAIL addr_hblank got %0d exp 8", rd_addr); end
    run_to(HT, 0);
    n_checks++;
    if (rd_addr !== 19'd8) begin n_fail++; $display("FAIL addr_line1 got %0d exp 8", rd_addr); end
  endtask

  // Blank from pixel (2,3) through pixel (5,4), then re-enable.
  task automatic test_display_en();
    int pn, q, blanked = 0;
    logic en;
    run_to(0, 0);
    for (int i = 0; i < FR + 2; i++) begin
      pn = k + 1 - 2;
      q  = pn % FR;
      en = !(q >= 3 * HT + 2 && q <= 4 * HT + 5);
      display_en = en;
      step();
      e = exp_pins(k - 2, en);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL display_en p=%0d got %h exp %h", k - 2, obs, e); end
      if (!en && de) blanked++;
    end
    display_en = 1'b1;
    n_checks++;
    if (blanked != 6 + 6) begin n_fail++; $display("FAIL blanked_pixels got %0d exp 12", blanked); end
  endtask

  task automatic test_midframe_reset();
    int fs_n = 0, de_hi = 0, p;
    run_to(4 * HT + 3, 0);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 16'hC000) begin n_fail++; $display("FAIL async_reset_pins got %h exp c000", obs); end
    n_checks++;
    if (rd_addr !== 19'd0) begin n_fail++; $display("FAIL async_reset_addr got %0d exp 0", rd_addr); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== 16'hC000) begin n_fail++; $display("FAIL reset_held_pins got %h exp c000", obs); end
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < FR + 1; i++) begin
      step();
      p = k - 2;
      e = exp_pins(p, 1'b1);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL post_reset p=%0d got %h exp %h", p, obs, e); end
      if (k == 2) begin
        n_checks++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL post_reset_fs got %b exp 1", frame_start); end
      end
      if (p >= 0 && p < FR) begin
        if (frame_start) fs_n++;
        if (de) de_hi++;
      end
    end
    n_checks++;
    if (fs_n != 1) begin n_fail++; $display("FAIL post_reset_fs_count got %0d exp 1", fs_n); end
    n_checks++;
    if (de_hi != HA * VA) begin n_fail++; $display("FAIL post_reset_de_count got %0d exp %0d", de_hi, HA * VA); end
  endtask

  task automatic test_frame_start();
    int fs_n = 0, p;
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      p = k - 2;
      if (frame_start) begin
        fs_n++;
        n_checks++;
        if (!(de === 1'b1 && p % FR == 0)) begin
          n_fail++; $display("FAIL fs_position p=%0d de=%b exp de=1 at frame origin", p, de);
        end
      end
    end
    n_checks++;
    if (fs_n != 3) begin n_fail++; $display("FAIL fs_three_frames got %0d exp 3", fs_n); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_pixel_data();
    test_rd_addr();
    test_display_en();
    test_midframe_reset();
    test_frame_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
